// File: rtl/rns_proc_pkg.sv
// Shared definitions for the processor data-memory path: default widths,
// arbiter state encoding and read-return owner tags.
package rns_proc_pkg;

   localparam int DMEM_ADDR_W = 16;
   localparam int DMEM_DATA_W = 8;

   typedef enum logic {
      S_NORM  = 1'b0,
      S_FORCE = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear. Clear has priority over increment and
// the count holds at MAX_VAL once reached.
module sat_counter
   import rns_proc_pkg::*;
#(
   parameter int MAX_VAL = 4,
   parameter int WIDTH   = $clog2(MAX_VAL + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   // next count: clear wins, increment stops at the ceiling
   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (inc && (count_reg != MAX_CNT)) begin
         count_next = count_reg + WIDTH'(1);
      end
   end

   // count register, cleared while reset is low
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and the debug/DMA port.
// CPU has priority; a run of MAX_WAIT denied DBG cycles opens a forced DBG
// window of up to BURST_LEN beats. Load data is steered back to whichever
// port issued the read on the previous cycle.
module dmem_port_arbiter
   import rns_proc_pkg::*;
#(
   parameter int ADDR_W    = DMEM_ADDR_W,
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_LEN = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int BEAT_W = $clog2(BURST_LEN + 1);
   // wait count seen on the cycle whose denial completes the MAX_WAIT run
   localparam logic [WAIT_W-1:0] WAIT_PRE  = WAIT_W'(MAX_WAIT - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

   arb_state_t        state_reg, state_next;
   owner_t            rd_owner_reg, rd_owner_next;
   logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_inc;
   logic              wait_clr;

   sat_counter #(
      .MAX_VAL (MAX_WAIT)
   ) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (wait_inc),
      .clr   (wait_clr),
      .count (wait_cnt)
   );

   // grant selection: CPU first in normal mode, DBG first inside a forced window
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (reset) begin
         if (state_reg == S_FORCE) begin
            dbg_gnt = dbg_req;
            cpu_gnt = cpu_req && !dbg_req;
         end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req && !cpu_req;
         end
      end
   end

   // memory port mux follows the granted requester, idle bus is all zero
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dbg_gnt) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   // read return: only the owner of last cycle's read sees data
   always_comb begin
      cpu_stall  = reset && cpu_req && !cpu_gnt;
      cpu_rvalid = reset && (rd_owner_reg == OWN_CPU);
      dbg_rvalid = reset && (rd_owner_reg == OWN_DBG);
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
      dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
   end

   // next state, beat count, starvation counter control and read owner
   always_comb begin
      state_next    = state_reg;
      beat_cnt_next = beat_cnt_reg;
      wait_inc      = 1'b0;
      wait_clr      = 1'b0;
      rd_owner_next = OWN_NONE;
      if (cpu_gnt && !cpu_we) begin
         rd_owner_next = OWN_CPU;
      end else if (dbg_gnt && !dbg_we) begin
         rd_owner_next = OWN_DBG;
      end
      if (state_reg == S_NORM) begin
         if (dbg_req && !dbg_gnt) begin
            wait_inc = 1'b1;
            if (wait_cnt >= WAIT_PRE) begin
               state_next    = S_FORCE;
               beat_cnt_next = '0;
            end
         end else begin
            wait_clr = 1'b1;
         end
      end else begin
         // the counter is held clear for the whole window so that normal
         // mode always restarts the starvation count from zero
         wait_clr = 1'b1;
         if (!dbg_req) begin
            state_next = S_NORM;
         end else begin
            beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
            if (beat_cnt_reg == BEAT_LAST) begin
               state_next = S_NORM;
            end
         end
      end
   end

   // state, beat counter and read-owner registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= S_NORM;
         beat_cnt_reg <= '0;
         rd_owner_reg <= OWN_NONE;
      end else begin
         state_reg    <= state_next;
         beat_cnt_reg <= beat_cnt_next;
         rd_owner_reg <= rd_owner_next;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed stimulus, a behavioural reference
// model compared on every cycle, and literal expectations per scenario.
module tb_dmem_port_arbiter;

   localparam int MAX_WAIT  = 4;
   localparam int BURST_LEN = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [15:0] dbg_addr = '0;
   logic [7:0]  dbg_wdata = '0;
   logic        cpu_gnt, cpu_stall, cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        dbg_gnt, dbg_rvalid;
   logic [7:0]  dbg_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   bit run      = 1'b0;

   dmem_port_arbiter #(
      .ADDR_W    (16),
      .DATA_W    (8),
      .MAX_WAIT  (MAX_WAIT),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_stall  (cpu_stall),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   // synchronous single-port data memory
   logic [7:0] mem_array [0:65535];
   always @(posedge clk) begin
      if (mem_en && mem_we) mem_array[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem_array[mem_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  shadow [0:65535];
   bit          m_forced = 1'b0;
   int          m_denied = 0;
   int          m_beats  = 0;
   int          m_pend   = 0;      // 0 none, 1 cpu, 2 dbg
   logic [7:0]  m_pend_data = '0;
   logic        e_cg, e_dg, e_crv, e_drv, e_stall, e_en, e_we;
   logic [15:0] e_addr;
   logic [7:0]  e_wd, e_crd, e_drd;
   logic [46:0] e_vec, a_vec;

   always @(negedge clk) begin
      if (run) begin
         e_cg = 0; e_dg = 0; e_crv = 0; e_drv = 0; e_stall = 0; e_en = 0; e_we = 0;
         e_addr = '0; e_wd = '0; e_crd = '0; e_drd = '0;
         if (reset) begin
            e_crv = (m_pend == 1);
            e_drv = (m_pend == 2);
            if (e_crv) e_crd = m_pend_data;
            if (e_drv) e_drd = m_pend_data;
            if (m_forced) begin
               e_dg = dbg_req;
               e_cg = cpu_req && !dbg_req;
            end else begin
               e_cg = cpu_req;
               e_dg = dbg_req && !cpu_req;
            end
            e_stall = cpu_req && !e_cg;
            if (e_cg) begin
               e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
            end else if (e_dg) begin
               e_en = 1; e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata;
            end
         end
         e_vec = {e_cg, e_stall, e_crv, e_crd, e_dg, e_drv, e_drd, e_en, e_we, e_addr, e_wd};
         a_vec = {cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
                  mem_en, mem_we, mem_addr, mem_wdata};
         n_checks++;
         if (a_vec !== e_vec) begin
            n_fail++;
            $display("FAIL model_cycle @%0t: got 0x%0h, required 0x%0h", $time, a_vec, e_vec);
         end
         // advance the model to the state after the coming clock edge
         if (!reset) begin
            m_forced = 0; m_denied = 0; m_beats = 0; m_pend = 0;
         end else begin
            m_pend = 0;
            if (e_cg) begin
               if (cpu_we) shadow[cpu_addr] = cpu_wdata;
               else begin m_pend = 1; m_pend_data = shadow[cpu_addr]; end
            end
            if (e_dg) begin
               if (dbg_we) shadow[dbg_addr] = dbg_wdata;
               else begin m_pend = 2; m_pend_data = shadow[dbg_addr]; end
            end
            if (!m_forced) begin
               if (dbg_req && !e_dg) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
               else m_denied = 0;
               if (m_denied == MAX_WAIT) begin
                  m_forced = 1; m_beats = 0; m_denied = 0;
               end
            end else begin
               m_denied = 0;
               if (!dbg_req) m_forced = 0;
               else begin
                  m_beats++;
                  if (m_beats == BURST_LEN) m_forced = 0;
               end
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   logic [15:0] exp_c, exp_d;
   logic [7:0]  ev;

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem_array[i] <= pat(i[15:0]);
         shadow[i] = pat(i[15:0]);
      end
      run = 1'b1;

      // 1: reset with both requests pending
      reset = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0000;
      dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0001;
      for (int k = 0; k < 3; k++) begin
         smp();
         check("rst_outputs", {cpu_gnt, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid, cpu_stall}, 0);
         nxt();
      end
      reset = 1;
      smp();
      check("rst_release_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
      nxt();

      // 2: CPU store then load of 0x0010
      dbg_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
      smp();
      check("cpu_store_bus", {cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {3'b111, 16'h0010, 8'h5A});
      nxt();
      cpu_we = 0;
      smp();
      check("cpu_load_bus", {cpu_gnt, mem_en, mem_we, mem_addr}, {3'b110, 16'h0010});
      nxt();
      cpu_req = 0;
      smp();
      check("cpu_load_data", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h5A});
      check("dbg_idle_data", {dbg_rvalid, dbg_rdata}, 0);
      nxt();

      // 3: starvation -> forced window of BURST_LEN beats
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 8'h33;
      dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020;
      exp_c = 16'b0000_0000_1100_1111;
      exp_d = 16'b0000_0000_0011_0000;
      for (int k = 0; k < 8; k++) begin
         smp();
         check("starve_pattern", {cpu_gnt, dbg_gnt, cpu_stall}, {exp_c[k], exp_d[k], !exp_c[k]});
         nxt();
      end
      cpu_req = 0; dbg_req = 0;
      nxt();

      // 4: back-to-back DBG reads of 0..3
      for (int k = 0; k < 5; k++) begin
         dbg_req = (k < 4); dbg_we = 0; dbg_addr = 16'(k);
         smp();
         if (k < 4) check("dbg_burst_gnt", dbg_gnt, 1'b1);
         if (k >= 1) begin
            ev = 8'hA5 ^ 8'(k - 1);
            check("dbg_burst_data", {dbg_rvalid, dbg_rdata}, {1'b1, ev});
         end
         nxt();
      end
      smp();
      check("dbg_burst_end", dbg_rvalid, 1'b0);
      nxt();

      // 5: forced window closed early by dbg_req dropping after one beat
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 8'h77;
      dbg_we = 0; dbg_addr = 16'h0060;
      exp_c = 16'b0000_0011_1110_1111;
      exp_d = 16'b0000_0100_0001_0000;
      for (int k = 0; k < 11; k++) begin
         dbg_req = (k != 5);
         smp();
         check("early_close", {cpu_gnt, dbg_gnt}, {exp_c[k], exp_d[k]});
         nxt();
      end
      cpu_req = 0; dbg_req = 0;
      nxt();

      // 6: reset while a DBG read is outstanding
      dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0005;
      smp();
      check("dbg_read_gnt", dbg_gnt, 1'b1);
      nxt();
      reset = 0; dbg_req = 0;
      smp();
      check("rst_drops_read", {dbg_rvalid, dbg_rdata, cpu_rvalid}, 0);
      nxt();
      nxt();
      reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0000; dbg_req = 1;
      for (int k = 0; k < 5; k++) begin
         smp();
         if (k == 0) check("post_rst_no_rvalid", dbg_rvalid, 1'b0);
         check("post_rst_arb", {cpu_gnt, dbg_gnt}, (k < 4) ? 2'b10 : 2'b01);
         nxt();
      end
      cpu_req = 0; dbg_req = 0;
      nxt();
      nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
